mem_stage_hs: RTL
=================

// Module: mem_stage_hs
// PURPOSE
//  Parametrised MEM stage with a memory-response handshake. Latches the EX-stage result, waits a
//  variable number of cycles for load data, aligns and extends it, and selects the write-back value.
//  Back-pressures the pipeline while a load is outstanding.
//  Sits between the EX stage and the register-file write port.
//  Unlike the fixed-latency stage, memory may answer late or never; this stage recovers via timeout.
// PARAMETERS
//  TIMEOUT_CYC  255  cycles in WAIT/DRAIN without mem_rvalid before bus error (1..65535)
//  PC_W         32   width of the PC carried alongside the instruction
// PORTS
//  clk         in   1     clock
//  rst         in   1     synchronous, active-high reset
//  flush       in   1     kill instruction in stage (exception/redirect)
//  stall       in   1     downstream/global stall; holds stage contents
//  mem_ctrl    in   3     000 lb,001 lh,010 lwl,011 lw,100 lbu,101 lhu,110 lwr,111 no load
//  wb_src      in   3     000 ALU,001 mem,010 HI,011 LO,100 CP0, others -> 0
//  wb_reg_in   in   5     destination register (0 = none)
//  alu_out     in   32    ALU result / effective address
//  rt_fwd      in   32    forwarded rt (merge source for lwl/lwr)
//  reg_hi      in   32    HI value (combinational)
//  reg_lo      in   32    LO value (combinational)
//  cp0_out     in   32    CP0 read value (combinational)
//  mem_rvalid  in   1     load data valid this cycle
//  mem_rdata   in   32    load data word
//  pc_in       in   PC_W  PC of incoming instruction
//  bd_in       in   1     incoming instruction is in a delay slot
//  stall_out   out  1     stage busy; upstream must hold
//  wb_reg_out  out  5     write-back register (0 when no valid result)
//  wb_data     out  32    write-back data
//  pc_out      out  PC_W  PC of instruction in stage
//  bd_out      out  1     delay-slot flag of instruction in stage
//  bus_err     out  1     1-cycle pulse: load timed out
// BEHAVIOUR
//  - Reset: state IDLE; mem_ctrl_r=111; wb_src_r=000; wb_reg_r=0; timer=0.
//    Outputs after reset: stall_out=0, wb_reg_out=0, bus_err=0, pc_out=0, bd_out=0.
//  - Latch: when state in {IDLE,DONE} and !stall, register all inputs. If flush: mem_ctrl_r=111,
//    wb_reg_r=0, wb_src_r=0.
//  - FSM: IDLE -> WAIT on latching mem_ctrl!=111 (not flushed). WAIT: on mem_rvalid capture
//    mem_rdata into rdata_r, go DONE.
//    DONE -> IDLE or WAIT (next latch) when !stall; stays DONE under stall.
//    WAIT + flush -> DRAIN (instruction killed, wb_reg_r=0). DRAIN: next mem_rvalid is discarded, then IDLE.
//  - Timeout: timer counts cycles in WAIT/DRAIN, cleared on entry. Reaching TIMEOUT_CYC with no rvalid:
//    bus_err pulses 1 cycle, wb_reg_r=0, go IDLE (DRAIN timeout also pulses bus_err).
//  - stall_out = (state==WAIT)|(state==DRAIN). stall does not affect WAIT; rvalid is never lost.
//  - wb_reg_out = wb_reg_r in IDLE/DONE, 0 in WAIT/DRAIN. Non-loads: result visible the cycle after latch.
//    Loads: result visible the cycle after mem_rvalid (DONE).
//  - Alignment on rdata_r with a=alu_out_r[1:0]:
//    lb/lbu: byte a, sign-/zero-extended. lh/lhu: half a[1], sign-/zero-extended.
//    lwl: a=0 {d[7:0],rt[23:0]}, 1 {d[15:0],rt[15:0]}, 2 {d[23:0],rt[7:0]}, 3 d.
//    lwr: a=0 d, 1 {rt[31:24],d[31:8]}, 2 {rt[31:16],d[31:16]}, 3 {rt[31:8],d[31:24]}.
//    lw: d.
//  - wb_data combinational from wb_src_r; mem source with mem_ctrl_r=111 yields 0.
//  - Simultaneous: rvalid and timeout expiry in the same cycle -> rvalid wins, no bus_err.
//  - rvalid in IDLE/DONE: ignored.
// CONFIGURATION
//  MEM_ALIGN_EXC_EN defined: at latch, lh/lhu with a[0]=1 or lw with a!=0 suppresses the wait.
//    It forces wb_reg_r=0, stays IDLE, and pulses output adel (1 bit, 1 cycle, reset 0) the next cycle.
//    The adel port exists only when the macro is defined.
//  MEM_ALIGN_EXC_EN undefined: no port; misaligned addresses use the low-bit selection above
//    (lw ignores a, lh uses a[1]).
// TESTING
//  1 ALU op wb_src=000, alu_out=0x12345678, wb_reg=5 -> next cycle wb_reg_out=5, wb_data=0x12345678, stall_out=0.
//  2 lb a=3, rvalid after 4 cycles with data 0x80AABBCC -> stall_out high 4 cycles;
//    then wb_data=0xFFFFFF80, wb_reg_out valid for one cycle.
//  3 lwl a=1, rt=0x11223344, data 0xAABBCCDD -> wb_data=0xCCDD3344; lwr a=2 same inputs -> 0x1122AABB.
//  4 load, flush in WAIT, rvalid 2 cycles later -> data discarded, wb_reg_out=0;
//    next instruction latched after DRAIN exits.
//  5 TIMEOUT_CYC=8, load with no rvalid -> bus_err pulse on the 8th WAIT cycle, wb_reg_out=0, stall_out drops.
//  6 MEM_ALIGN_EXC_EN, lw a=2 -> adel pulse, no stall, wb_reg_out=0; without macro -> wb_data=raw word.

Source files
------------

// File: rtl/mem_stage_hs.sv
// mem_stage_hs: MEM pipeline stage with a variable-latency load handshake.
// Latches the EX result, waits for mem_rvalid on loads, aligns and extends the
// returned word, and selects the write-back value. A load that is flushed while
// waiting drains the late response. A load with no response recovers through a
// timeout that raises a one-cycle bus_err.
// Optional feature macro: MEM_ALIGN_EXC_EN. When defined, misaligned lh/lhu/lw
// raise a one-cycle adel pulse instead of waiting for memory.
module mem_stage_hs #(
    parameter int TIMEOUT_CYC = 255,
    parameter int PC_W        = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            stall,
    input  logic [2:0]      mem_ctrl,
    input  logic [2:0]      wb_src,
    input  logic [4:0]      wb_reg_in,
    input  logic [31:0]     alu_out,
    input  logic [31:0]     rt_fwd,
    input  logic [31:0]     reg_hi,
    input  logic [31:0]     reg_lo,
    input  logic [31:0]     cp0_out,
    input  logic            mem_rvalid,
    input  logic [31:0]     mem_rdata,
    input  logic [PC_W-1:0] pc_in,
    input  logic            bd_in,
    output logic            stall_out,
    output logic [4:0]      wb_reg_out,
    output logic [31:0]     wb_data,
    output logic [PC_W-1:0] pc_out,
    output logic            bd_out,
    output logic            bus_err
`ifdef MEM_ALIGN_EXC_EN
    ,
    output logic            adel
`endif
);

    localparam logic [1:0]  S_IDLE  = 2'd0;
    localparam logic [1:0]  S_WAIT  = 2'd1;
    localparam logic [1:0]  S_DONE  = 2'd2;
    localparam logic [1:0]  S_DRAIN = 2'd3;

    localparam logic [2:0]  CTRL_NONE = 3'b111;
    localparam logic [15:0] TMAX      = 16'(TIMEOUT_CYC - 1);

    logic [1:0]      state_q, state_d;
    logic [2:0]      ctrl_q, ctrl_d;
    logic [2:0]      src_q, src_d;
    logic [4:0]      reg_q, reg_d;
    logic [31:0]     alu_q, alu_d;
    logic [31:0]     rt_q, rt_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            bd_q, bd_d;
    logic [15:0]     timer_q, timer_d;

    logic            busy;
    logic            can_latch;
    logic            expire;
    logic            misalign;
    logic [31:0]     load_val;

    assign busy      = (state_q == S_WAIT) || (state_q == S_DRAIN);
    assign can_latch = ((state_q == S_IDLE) || (state_q == S_DONE)) && !stall;
    assign expire    = busy && (timer_q == TMAX);

`ifdef MEM_ALIGN_EXC_EN
    logic adel_q, adel_d;

    // Misaligned halfword/word loads are rejected at latch time.
    assign misalign = (((mem_ctrl == 3'b001) || (mem_ctrl == 3'b101)) && alu_out[0]) ||
                      ((mem_ctrl == 3'b011) && (alu_out[1:0] != 2'b00));
    assign adel_d   = can_latch && !flush && (mem_ctrl != CTRL_NONE) && misalign;
    assign adel     = adel_q;

    // Address-error pulse appears the cycle after the rejected latch.
    always_ff @(posedge clk) begin
        if (rst) adel_q <= 1'b0;
        else     adel_q <= adel_d;
    end
`else
    assign misalign = 1'b0;
`endif

    // Next-state: latch from upstream, wait/drain the memory response, timeout.
    always_comb begin
        state_d = state_q;
        ctrl_d  = ctrl_q;
        src_d   = src_q;
        reg_d   = reg_q;
        alu_d   = alu_q;
        rt_d    = rt_q;
        rdata_d = rdata_q;
        pc_d    = pc_q;
        bd_d    = bd_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (!stall) begin
                    ctrl_d  = mem_ctrl;
                    src_d   = wb_src;
                    reg_d   = wb_reg_in;
                    alu_d   = alu_out;
                    rt_d    = rt_fwd;
                    pc_d    = pc_in;
                    bd_d    = bd_in;
                    state_d = S_IDLE;
                    if (flush) begin
                        ctrl_d = CTRL_NONE;
                        reg_d  = '0;
                        src_d  = '0;
                    end else if (mem_ctrl != CTRL_NONE) begin
                        if (misalign) reg_d = '0;
                        else          state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // A response always wins over timeout and flush so it is never lost.
                if (mem_rvalid) begin
                    rdata_d = mem_rdata;
                    if (flush) begin
                        reg_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (expire) begin
                    reg_d   = '0;
                    state_d = S_IDLE;
                end else if (flush) begin
                    reg_d   = '0;
                    state_d = S_DRAIN;
                end
            end
            default: begin
                // DRAIN: swallow the late response of a killed load.
                if (mem_rvalid || expire) state_d = S_IDLE;
            end
        endcase
        // Timer runs only while staying in WAIT or DRAIN; any entry restarts it.
        timer_d = (busy && (state_d == state_q)) ? timer_q + 16'd1 : 16'd0;
    end

    // Stage registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ctrl_q  <= CTRL_NONE;
            src_q   <= '0;
            reg_q   <= '0;
            alu_q   <= '0;
            rt_q    <= '0;
            rdata_q <= '0;
            pc_q    <= '0;
            bd_q    <= 1'b0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            src_q   <= src_d;
            reg_q   <= reg_d;
            alu_q   <= alu_d;
            rt_q    <= rt_d;
            rdata_q <= rdata_d;
            pc_q    <= pc_d;
            bd_q    <= bd_d;
            timer_q <= timer_d;
        end
    end

    // Load alignment: byte/half select with extension, lwl/lwr merge with rt.
    always_comb begin
        logic [7:0]  b;
        logic [15:0] h;
        case (alu_q[1:0])
            2'd0:    b = rdata_q[7:0];
            2'd1:    b = rdata_q[15:8];
            2'd2:    b = rdata_q[23:16];
            default: b = rdata_q[31:24];
        endcase
        h = alu_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        load_val = '0;
        case (ctrl_q)
            3'b000: load_val = {{24{b[7]}}, b};
            3'b001: load_val = {{16{h[15]}}, h};
            3'b100: load_val = {24'd0, b};
            3'b101: load_val = {16'd0, h};
            3'b011: load_val = rdata_q;
            3'b010: begin
                case (alu_q[1:0])
                    2'd0:    load_val = {rdata_q[7:0],  rt_q[23:0]};
                    2'd1:    load_val = {rdata_q[15:0], rt_q[15:0]};
                    2'd2:    load_val = {rdata_q[23:0], rt_q[7:0]};
                    default: load_val = rdata_q;
                endcase
            end
            3'b110: begin
                case (alu_q[1:0])
                    2'd0:    load_val = rdata_q;
                    2'd1:    load_val = {rt_q[31:24], rdata_q[31:8]};
                    2'd2:    load_val = {rt_q[31:16], rdata_q[31:16]};
                    default: load_val = {rt_q[31:8],  rdata_q[31:24]};
                endcase
            end
            default: load_val = '0;
        endcase
    end

    // Write-back source select.
    always_comb begin
        case (src_q)
            3'b000:  wb_data = alu_q;
            3'b001:  wb_data = load_val;
            3'b010:  wb_data = reg_hi;
            3'b011:  wb_data = reg_lo;
            3'b100:  wb_data = cp0_out;
            default: wb_data = '0;
        endcase
    end

    assign stall_out  = busy;
    assign wb_reg_out = busy ? 5'd0 : reg_q;
    assign pc_out     = pc_q;
    assign bd_out     = bd_q;
    assign bus_err    = expire && !mem_rvalid;

endmodule
